dot_matrix_frame_writer: RTL
============================

// Module: dot_matrix_frame_writer
// PURPOSE
//  Producer side of the 8x8 red/green dot-matrix frame interface. Holds a staging
//  (back) image and a displayed (front) image. Row writes go to the back image.
//  A commit copies the back image to the front image on the next scanner frame
//  boundary, so the row scanner never shows a half-updated frame.
//  Also provides optional whole-frame blinking. Sits between the fan-state and
//  pattern logic and the dynamic row-scan driver. The scanner consumes
//  dot_matrix_R/G, with row k at bits [8k+7:8k].
// PARAMETERS
//  DEFAULT_R     64'h0  red image loaded into back, front and outputs at reset
//  DEFAULT_G     64'h0  green image loaded into back, front and outputs at reset
//  BLINK_FRAMES  4      frame_sync pulses per blink half-period; range 1..255
// PORTS
//  clk_in          in   1   system clock (same clock as the row scanner)
//  rst             in   1   asynchronous reset, active-high
//  wr_valid        in   1   row write request
//  wr_ready        out  1   row write accepted when wr_valid & wr_ready
//  wr_row          in   3   row index 0..7 (0 = bottom line)
//  wr_r            in   8   red column byte for wr_row
//  wr_g            in   8   green column byte for wr_row
//  commit          in   1   1-cycle pulse: request back->front copy
//  frame_sync      in   1   1-cycle pulse from scanner at row 7 -> row 0 wrap
//  blink_en        in   1   level: enable whole-frame blinking
//  commit_pending  out  1   high while a commit waits for frame_sync
//  swap_done       out  1   1-cycle pulse: new front image now on outputs
//  dot_matrix_R    out  64  red image to the scanner
//  dot_matrix_G    out  64  green image to the scanner
// BEHAVIOUR
//  Reset (async, rst=1):
//   - back = front = dot_matrix_R/G = DEFAULT_R/G
//   - state = IDLE; commit_pending = 0; swap_done = 0
//   - blink counter = 0; blink phase = 0 (visible)
//   - rst mid-PENDING aborts the commit and discards all staged writes
//  FSM, 2 states:
//   - IDLE:    wr_ready = 1. commit=1 -> PENDING.
//   - PENDING: wr_ready = 0; commit_pending = 1. Further commits are ignored.
//     On frame_sync=1: front <= back, then -> IDLE.
//   - wr_ready and commit_pending are decoded from the state register only.
//  Write:
//   - Accepted write at edge N sets back[8*wr_row +: 8] <= wr_r / wr_g.
//   - No other bits of back change.
//   - The back image is never cleared by a swap. Back == front after the copy,
//     so incremental row edits stay valid.
//  Simultaneous events:
//   - IDLE, wr_valid & commit in the same cycle: the write is accepted AND is
//     part of the committed image.
//   - IDLE, commit & frame_sync in the same cycle: no copy. The copy waits for
//     the next frame_sync, so a full frame of the old image is always shown.
//   - PENDING, wr_valid=1: the write is not accepted. wr_valid may stay high.
//  Output timing:
//   - Outputs are registered every cycle from front, or 0 when blanked.
//   - frame_sync in PENDING at edge N: front updates at N, outputs at N+1.
//   - swap_done is high in the cycle after edge N+1 (output value valid).
//   - Commit-to-display latency is 2 cycles plus the wait for frame_sync.
//  Blink:
//   - blank = blink_en & phase.
//   - Counter counts frame_sync pulses 0..BLINK_FRAMES-1. At wrap, phase toggles.
//   - blink_en=0 clears counter and phase in the same cycle (visible next cycle).
//   - Blanking applies to both R and G outputs. front and back are unaffected.
//   - A swap while blanked still pulses swap_done.
// TESTING
//  1 Reset with DEFAULT_R=64'hFF: dot_matrix_R=64'hFF, G=0, wr_ready=1,
//    commit_pending=0, swap_done=0.
//  2 Write row3 r=8'hA5 g=8'h3C, commit, frame_sync 5 cycles later ->
//    outputs unchanged until sync. Then R[31:24]=A5, G[31:24]=3C,
//    all other bits = default. One swap_done pulse.
//  3 commit and frame_sync in the same cycle -> commit_pending=1, no change.
//    Next frame_sync -> swap.
//  4 wr_valid held high through PENDING -> wr_ready=0 and back unchanged.
//    The write is accepted in the first IDLE cycle after the swap.
//  5 blink_en=1, BLINK_FRAMES=2, 8 frame_syncs -> outputs alternate
//    visible/0 every 2 frames. Drop blink_en -> image visible next cycle.
//  6 rst pulse while PENDING with staged rows -> all images = defaults,
//    state IDLE, no swap_done.

Source files
------------

// File: rtl/dot_matrix_frame_writer.sv
// rtl/dot_matrix_frame_writer.sv - double-buffered 8x8 red/green frame writer with frame-synchronous swap and blink
module dot_matrix_frame_writer #(
  parameter logic [63:0] DEFAULT_R    = 64'h0,
  parameter logic [63:0] DEFAULT_G    = 64'h0,
  parameter int          BLINK_FRAMES = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_r,
  input  logic [7:0]  wr_g,
  input  logic        commit,
  input  logic        frame_sync,
  input  logic        blink_en,
  output logic        commit_pending,
  output logic        swap_done,
  output logic [63:0] dot_matrix_R,
  output logic [63:0] dot_matrix_G
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        copy_en;
  logic        wr_fire;
  logic [63:0] back_r_q, back_r_d;
  logic [63:0] back_g_q, back_g_d;
  logic [63:0] front_r_q, front_g_q;
  logic [63:0] out_r_q, out_g_q;
  logic        swapped_q;
  logic        swap_done_q;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic        blank;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A commit landing on a frame_sync cycle still waits a full frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (frame_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    copy_en        = 1'b0;
    case (state_q)
      IDLE:    wr_ready = 1'b1;
      PENDING: begin
        commit_pending = 1'b1;
        copy_en        = frame_sync;
      end
      default: ;
    endcase
  end

  assign wr_fire = wr_valid & wr_ready;

  always_comb begin
    back_r_d = back_r_q;
    back_g_d = back_g_q;
    if (wr_fire) begin
      back_r_d[{wr_row, 3'b000} +: 8] = wr_r;
      back_g_d[{wr_row, 3'b000} +: 8] = wr_g;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
    end else if (frame_sync) begin
      if (blink_cnt_q >= BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  assign blank = blink_en & phase_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      back_r_q    <= DEFAULT_R;
      back_g_q    <= DEFAULT_G;
      front_r_q   <= DEFAULT_R;
      front_g_q   <= DEFAULT_G;
      out_r_q     <= DEFAULT_R;
      out_g_q     <= DEFAULT_G;
      swapped_q   <= 1'b0;
      swap_done_q <= 1'b0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      back_r_q    <= back_r_d;
      back_g_q    <= back_g_d;
      if (copy_en) begin
        front_r_q <= back_r_q;
        front_g_q <= back_g_q;
      end
      out_r_q     <= blank ? 64'h0 : front_r_q;
      out_g_q     <= blank ? 64'h0 : front_g_q;
      // swap_done trails the copy by one cycle so it marks the new image on the outputs.
      swapped_q   <= copy_en;
      swap_done_q <= swapped_q;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign swap_done    = swap_done_q;
  assign dot_matrix_R = out_r_q;
  assign dot_matrix_G = out_g_q;

endmodule
